// File: rtl/interface_demux_v2.sv
// Egress demux: pops descriptors and bytes from the core egress FIFOs and
// replicates each frame into the TX FIFO pairs of its destination ports.
module interface_demux_v2 #(
  parameter int unsigned LEN_MAX = 1536
) (
  input  logic        clk_sys,
  input  logic        rstn_sys,
  output logic        sfifo_rd,
  input  logic [7:0]  sfifo_dout,
  output logic        ptr_sfifo_rd,
  input  logic [15:0] ptr_sfifo_dout,
  input  logic        ptr_sfifo_empty,
  output logic        tx_data_fifo_wr0,
  output logic        tx_data_fifo_wr1,
  output logic        tx_data_fifo_wr2,
  output logic        tx_data_fifo_wr3,
  output logic [7:0]  tx_data_fifo_din0,
  output logic [7:0]  tx_data_fifo_din1,
  output logic [7:0]  tx_data_fifo_din2,
  output logic [7:0]  tx_data_fifo_din3,
  input  logic        tx_data_fifo_afull0,
  input  logic        tx_data_fifo_afull1,
  input  logic        tx_data_fifo_afull2,
  input  logic        tx_data_fifo_afull3,
  output logic        tx_ptr_fifo_wr0,
  output logic        tx_ptr_fifo_wr1,
  output logic        tx_ptr_fifo_wr2,
  output logic        tx_ptr_fifo_wr3,
  output logic [15:0] tx_ptr_fifo_din0,
  output logic [15:0] tx_ptr_fifo_din1,
  output logic [15:0] tx_ptr_fifo_din2,
  output logic [15:0] tx_ptr_fifo_din3,
  input  logic        tx_ptr_fifo_full0,
  input  logic        tx_ptr_fifo_full1,
  input  logic        tx_ptr_fifo_full2,
  input  logic        tx_ptr_fifo_full3,
  output logic [15:0] drop_cnt
);

  typedef enum logic [6:0] {
    S_IDLE    = 7'b000_0001,
    S_PTR_RD  = 7'b000_0010,
    S_PTR_LAT = 7'b000_0100,
    S_CHK     = 7'b000_1000,
    S_DATA    = 7'b001_0000,
    S_TAIL    = 7'b010_0000,
    S_PTR_WR  = 7'b100_0000
  } state_e;

  state_e      state_q;
  logic [3:0]  mask_q;
  logic [10:0] len_q;
  logic [10:0] cnt_q;
  logic        err_q;
  logic        drop_q;
  logic        rd_q;
  logic        prd_q;
  logic [3:0]  wr_q;
  logic [3:0]  pwr_q;
  logic [15:0] pdin_q;
  logic [15:0] drop_cnt_q;

  logic [3:0]  afull_v;
  logic [3:0]  pfull_v;
  logic        drop_d;
  logic        ready_d;
  logic [15:0] drop_cnt_d;
  logic [7:0]  din_d;

  assign afull_v = {tx_data_fifo_afull3, tx_data_fifo_afull2,
                    tx_data_fifo_afull1, tx_data_fifo_afull0};
  assign pfull_v = {tx_ptr_fifo_full3, tx_ptr_fifo_full2,
                    tx_ptr_fifo_full1, tx_ptr_fifo_full0};

  assign drop_d = err_q | (mask_q == 4'd0)
                | (32'(len_q) > LEN_MAX);

  // Only ports named in the mask can hold the frame back.
  assign ready_d = ~|(mask_q & (afull_v | pfull_v));

  assign drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q
                    : drop_cnt_q + 16'd1;

  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      rd_q       <= 1'b0;
      prd_q      <= 1'b0;
      wr_q       <= '0;
      pwr_q      <= '0;
      pdin_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      prd_q <= 1'b0;
      pwr_q <= '0;
      wr_q  <= mask_q & {4{rd_q}};
      unique case (state_q)
        S_IDLE: begin
          if (!ptr_sfifo_empty) begin
            prd_q   <= 1'b1;
            state_q <= S_PTR_RD;
          end
        end
        S_PTR_RD: begin
          state_q <= S_PTR_LAT;
        end
        S_PTR_LAT: begin
          err_q   <= ptr_sfifo_dout[15];
          mask_q  <= ptr_sfifo_dout[14:11];
          len_q   <= ptr_sfifo_dout[10:0];
          state_q <= S_CHK;
        end
        S_CHK: begin
          drop_q <= drop_d;
          if (len_q == 11'd0) begin
            drop_cnt_q <= drop_cnt_d;
            state_q    <= S_IDLE;
          end else if (drop_d) begin
            // Dropped frames are still drained to keep the FIFOs aligned.
            mask_q  <= '0;
            rd_q    <= 1'b1;
            cnt_q   <= 11'd1;
            state_q <= S_DATA;
          end else if (ready_d) begin
            rd_q    <= 1'b1;
            cnt_q   <= 11'd1;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (cnt_q == len_q) begin
            rd_q    <= 1'b0;
            state_q <= S_TAIL;
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        S_TAIL: begin
          pwr_q   <= mask_q;
          pdin_q  <= {5'd0, len_q};
          state_q <= S_PTR_WR;
        end
        S_PTR_WR: begin
          if (drop_q) drop_cnt_q <= drop_cnt_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The FIFO output register already holds the byte in the write cycle;
  // gating keeps din at zero whenever no port is being written.
  assign din_d = (|wr_q) ? sfifo_dout : 8'h00;

  assign sfifo_rd     = rd_q;
  assign ptr_sfifo_rd = prd_q;

  assign tx_data_fifo_wr0 = wr_q[0];
  assign tx_data_fifo_wr1 = wr_q[1];
  assign tx_data_fifo_wr2 = wr_q[2];
  assign tx_data_fifo_wr3 = wr_q[3];

  assign tx_data_fifo_din0 = din_d;
  assign tx_data_fifo_din1 = din_d;
  assign tx_data_fifo_din2 = din_d;
  assign tx_data_fifo_din3 = din_d;

  assign tx_ptr_fifo_wr0 = pwr_q[0];
  assign tx_ptr_fifo_wr1 = pwr_q[1];
  assign tx_ptr_fifo_wr2 = pwr_q[2];
  assign tx_ptr_fifo_wr3 = pwr_q[3];

  assign tx_ptr_fifo_din0 = pdin_q;
  assign tx_ptr_fifo_din1 = pdin_q;
  assign tx_ptr_fifo_din2 = pdin_q;
  assign tx_ptr_fifo_din3 = pdin_q;

  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_interface_demux_v2.sv
// Randomised bench for interface_demux_v2 with a queue-based frame model
// of the upstream FIFOs and of what each TX port must receive.
module tb_interface_demux_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        sfifo_rd;
  logic [7:0]  sfifo_dout;
  logic        ptr_sfifo_rd;
  logic [15:0] ptr_sfifo_dout;
  logic        ptr_sfifo_empty;
  logic        wr0, wr1, wr2, wr3;
  logic [7:0]  din0, din1, din2, din3;
  logic        pwr0, pwr1, pwr2, pwr3;
  logic [15:0] pdin0, pdin1, pdin2, pdin3;
  logic [3:0]  afull, full;
  logic [15:0] drop_cnt;

  interface_demux_v2 dut (
    .clk_sys(clk), .rstn_sys(rstn),
    .sfifo_rd(sfifo_rd), .sfifo_dout(sfifo_dout),
    .ptr_sfifo_rd(ptr_sfifo_rd), .ptr_sfifo_dout(ptr_sfifo_dout),
    .ptr_sfifo_empty(ptr_sfifo_empty),
    .tx_data_fifo_wr0(wr0), .tx_data_fifo_wr1(wr1),
    .tx_data_fifo_wr2(wr2), .tx_data_fifo_wr3(wr3),
    .tx_data_fifo_din0(din0), .tx_data_fifo_din1(din1),
    .tx_data_fifo_din2(din2), .tx_data_fifo_din3(din3),
    .tx_data_fifo_afull0(afull[0]), .tx_data_fifo_afull1(afull[1]),
    .tx_data_fifo_afull2(afull[2]), .tx_data_fifo_afull3(afull[3]),
    .tx_ptr_fifo_wr0(pwr0), .tx_ptr_fifo_wr1(pwr1),
    .tx_ptr_fifo_wr2(pwr2), .tx_ptr_fifo_wr3(pwr3),
    .tx_ptr_fifo_din0(pdin0), .tx_ptr_fifo_din1(pdin1),
    .tx_ptr_fifo_din2(pdin2), .tx_ptr_fifo_din3(pdin3),
    .tx_ptr_fifo_full0(full[0]), .tx_ptr_fifo_full1(full[1]),
    .tx_ptr_fifo_full2(full[2]), .tx_ptr_fifo_full3(full[3]),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [3:0] mask;
    int         len;
    logic       drop;
  } desc_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0]  bq[$];
  logic [15:0] pq[$];
  desc_t       cons[$];
  desc_t       frames[$];
  logic [7:0]  eb[$];
  int          fdone = 0;
  int          exp_drop = 0;
  int          n_push = 0;

  logic [3:0]  wv_prev = 4'd0;
  logic [3:0]  af_prev = 4'd0;
  logic [3:0]  fl_prev = 4'd0;
  logic        rd_prev = 1'b0;
  desc_t       cur;
  int          rdn = 0;
  int          rd_total = 0;
  int          prd_total = 0;
  int          wr_cnt[4];
  int          ptr_cnt[4];
  int          rd_rise_cyc = 0;
  int          ptr_wr_cyc = 0;
  logic [15:0] last_ptr = 16'd0;
  int          wr_start[$];
  int          wr_end[$];
  logic        stop = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Upstream FIFOs: a read sampled at an edge presents data just after it.
  always @(posedge clk) begin : up_fifo
    logic r, pr;
    r  = sfifo_rd;
    pr = ptr_sfifo_rd;
    #1;
    if (rstn) begin
      if (r) begin
        chk("sfifo_underflow", 32'(bq.size() > 0), 32'd1);
        sfifo_dout = (bq.size() > 0) ? bq.pop_front() : 8'h00;
      end
      if (pr) ptr_sfifo_dout = (pq.size() > 0) ? pq.pop_front() : 16'h0;
    end
    ptr_sfifo_empty = (pq.size() == 0);
  end

  always @(negedge clk) begin : mon
    logic [3:0]  wv, pv;
    logic [7:0]  dv[4];
    logic [15:0] pdv[4];
    if (rstn) begin
      wv = {wr3, wr2, wr1, wr0};
      pv = {pwr3, pwr2, pwr1, pwr0};
      dv[0] = din0; dv[1] = din1; dv[2] = din2; dv[3] = din3;
      pdv[0] = pdin0; pdv[1] = pdin1; pdv[2] = pdin2; pdv[3] = pdin3;
      if (wv != 4'd0) begin
        if (frames.size() == 0 || eb.size() == 0) begin
          chk("data_unexpected", 32'(wv), 32'd0);
        end else begin
          chk("data_mask", 32'(wv), 32'(frames[0].mask));
          for (int i = 0; i < 4; i++)
            chk("data_byte", 32'(dv[i]), 32'(eb[0]));
          void'(eb.pop_front());
          fdone++;
        end
        for (int i = 0; i < 4; i++) if (wv[i]) wr_cnt[i]++;
      end
      if (pv != 4'd0) begin
        chk("ptr_data_overlap", 32'(wv), 32'd0);
        if (frames.size() == 0) begin
          chk("ptr_unexpected", 32'(pv), 32'd0);
        end else begin
          chk("ptr_mask", 32'(pv), 32'(frames[0].mask));
          for (int i = 0; i < 4; i++) if (pv[i]) begin
            chk("ptr_din", 32'(pdv[i]), 32'(frames[0].len));
            last_ptr = pdv[i];
          end
          chk("ptr_after_bytes", fdone, frames[0].len);
          void'(frames.pop_front());
          fdone = 0;
          ptr_wr_cyc = cyc;
        end
        for (int i = 0; i < 4; i++) if (pv[i]) ptr_cnt[i]++;
      end
      if (wv != 4'd0 && wv_prev == 4'd0) wr_start.push_back(cyc);
      if (wv == 4'd0 && wv_prev != 4'd0) wr_end.push_back(cyc - 1);
      if (sfifo_rd) begin
        rd_total++;
        if (!rd_prev) begin
          rd_rise_cyc = cyc;
          rdn = 0;
          if (cons.size() == 0) begin
            chk("rd_unexpected", 32'd1, 32'd0);
          end else begin
            cur = cons.pop_front();
            if (!cur.drop)
              chk("ready_at_start",
                  32'(|(cur.mask & (af_prev | fl_prev))), 32'd0);
          end
        end
        rdn++;
      end else if (rd_prev) begin
        chk("burst_len", rdn, cur.len);
      end
      if (ptr_sfifo_rd) prd_total++;
      wv_prev = wv;
      rd_prev = sfifo_rd;
      af_prev = afull;
      fl_prev = full;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic err, input logic [3:0] mask,
                      input int len, input int pat);
    desc_t d;
    logic [7:0] b;
    d.mask = mask;
    d.len  = len;
    d.drop = err || mask == 4'd0 || len > 1536;
    pq.push_back({err, mask, 11'(len)});
    n_push++;
    if (len == 0) exp_drop++;
    else begin
      cons.push_back(d);
      if (d.drop) exp_drop++;
      else frames.push_back(d);
    end
    for (int i = 0; i < len; i++) begin
      b = (pat < 0) ? 8'($urandom) : 8'(pat + i);
      bq.push_back(b);
      if (len > 0 && !d.drop) eb.push_back(b);
    end
    ptr_sfifo_empty = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!(pq.size() == 0 && cons.size() == 0 && frames.size() == 0)
           && n < bound) begin
      tick(1);
      n++;
    end
    chk("timeout", 32'(n < bound), 32'd1);
    tick(8);
    chk("drop_cnt_model", 32'(drop_cnt), exp_drop);
    chk("ptr_reads", prd_total, n_push);
    chk("bytes_left", bq.size(), 0);
  endtask

  task automatic clr_stats();
    for (int i = 0; i < 4; i++) begin
      wr_cnt[i] = 0;
      ptr_cnt[i] = 0;
    end
    wr_start.delete();
    wr_end.delete();
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_rd"}, 32'({sfifo_rd, ptr_sfifo_rd}), 32'd0);
    chk({nm, "_wr"}, 32'({wr3, wr2, wr1, wr0, pwr3, pwr2, pwr1, pwr0}),
        32'd0);
    chk({nm, "_din"}, {din3, din2, din1, din0}, 32'd0);
    chk({nm, "_pdin"}, 32'(pdin0 | pdin1 | pdin2 | pdin3), 32'd0);
    chk({nm, "_drop"}, 32'(drop_cnt), 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bq.delete(); pq.delete(); cons.delete();
    frames.delete(); eb.delete();
    fdone = 0; exp_drop = 0; n_push = 0; prd_total = 0;
    ptr_sfifo_empty = 1'b1;
    wv_prev = 4'd0;
    rd_prev = 1'b0;
    #1;
    chk_quiet("reset_async");
    tick(3);
    rstn = 1'b1;
    tick(2);
  endtask

  initial begin : stim
    int k, t, r0, ln;
    logic [3:0] m;
    rstn = 1'b0;
    afull = 4'd0;
    full = 4'd0;
    sfifo_dout = 8'h00;
    ptr_sfifo_dout = 16'h0;
    ptr_sfifo_empty = 1'b1;
    clr_stats();
    tick(3);
    chk_quiet("reset_state");
    rstn = 1'b1;
    tick(2);

    // Unicast to port 2 with a counting payload.
    clr_stats();
    k = cyc;
    push(1'b0, 4'b0100, 64, 0);
    wait_done(2000);
    chk("uni_rd_lat", rd_rise_cyc - k, 4);
    chk("uni_wr_lat", (wr_start.size() > 0) ? wr_start[0] - k : -1, 5);
    chk("uni_ptr_lat", ptr_wr_cyc - k, 69);
    chk("uni_cnt", {8'(wr_cnt[3]), 8'(wr_cnt[2]), 8'(wr_cnt[1]),
                    8'(wr_cnt[0])}, 32'h0040_0000);
    chk("uni_ptrs", {8'(ptr_cnt[3]), 8'(ptr_cnt[2]), 8'(ptr_cnt[1]),
                     8'(ptr_cnt[0])}, 32'h0001_0000);
    chk("uni_ptr_val", 32'(last_ptr), 32'h0040);

    // Multicast to ports 0, 1 and 3.
    clr_stats();
    push(1'b0, 4'b1011, 60, -1);
    wait_done(2000);
    chk("mc_cnt", {8'(wr_cnt[3]), 8'(wr_cnt[2]), 8'(wr_cnt[1]),
                   8'(wr_cnt[0])}, 32'h3C00_3C3C);
    chk("mc_ptrs", {8'(ptr_cnt[3]), 8'(ptr_cnt[2]), 8'(ptr_cnt[1]),
                    8'(ptr_cnt[0])}, 32'h0100_0101);
    chk("mc_ptr_val", 32'(last_ptr), 32'h003C);

    // Drops: empty mask, err, oversize; each followed by a good frame.
    clr_stats();
    r0 = rd_total;
    push(1'b0, 4'b0000, 100, -1);
    push(1'b0, 4'b0001, 60, -1);
    wait_done(2000);
    chk("drop0_rds", rd_total - r0, 160);
    chk("drop0_cnt", 32'(drop_cnt), 32'd1);
    chk("drop0_port0", wr_cnt[0], 60);
    clr_stats();
    push(1'b1, 4'b0001, 100, -1);
    push(1'b0, 4'b0001, 60, -1);
    wait_done(2000);
    chk("drop_err_cnt", 32'(drop_cnt), 32'd2);
    chk("drop_err_port0", wr_cnt[0], 60);
    clr_stats();
    r0 = rd_total;
    push(1'b0, 4'b0001, 1600, -1);
    push(1'b0, 4'b0001, 60, -1);
    wait_done(4000);
    chk("drop_long_rds", rd_total - r0, 1660);
    chk("drop_long_cnt", 32'(drop_cnt), 32'd3);
    chk("drop_long_port0", wr_cnt[0], 60);

    // Backpressure on port 1, then an unrelated port afull.
    afull[1] = 1'b1;
    r0 = rd_total;
    push(1'b0, 4'b0010, 40, -1);
    tick(20);
    chk("bp_hold_rds", rd_total - r0, 0);
    afull[1] = 1'b0;
    t = cyc;
    wait_done(2000);
    chk("bp_release_lat", rd_rise_cyc - t, 1);
    full[3] = 1'b1;
    push(1'b0, 4'b1000, 20, -1);
    tick(12);
    full[3] = 1'b0;
    t = cyc;
    wait_done(2000);
    chk("pfull_release_lat", rd_rise_cyc - t, 1);
    afull[2] = 1'b1;
    k = cyc;
    push(1'b0, 4'b0001, 30, -1);
    wait_done(2000);
    chk("other_afull_lat", rd_rise_cyc - k, 4);
    afull[2] = 1'b0;

    // Zero length, then a frame to show the FSM is back in IDLE.
    clr_stats();
    r0 = rd_total;
    push(1'b0, 4'b0001, 0, -1);
    wait_done(200);
    chk("zero_rds", rd_total - r0, 0);
    chk("zero_wrs", wr_cnt[0] + ptr_cnt[0], 0);
    chk("zero_cnt", 32'(drop_cnt), 32'd4);
    k = cyc;
    push(1'b0, 4'b0001, 8, -1);
    wait_done(200);
    chk("zero_then_lat", rd_rise_cyc - k, 4);

    // Back-to-back frames.
    clr_stats();
    for (int i = 0; i < 3; i++) push(1'b0, 4'b0100, 64, 16 * i);
    wait_done(2000);
    chk("b2b_bursts", wr_start.size(), 3);
    if (wr_start.size() == 3 && wr_end.size() == 3) begin
      chk("b2b_gap1", wr_start[1] - wr_end[0] - 1, 6);
      chk("b2b_gap2", wr_start[2] - wr_end[1] - 1, 6);
    end

    // Reset in the middle of frame 2.
    clr_stats();
    for (int i = 0; i < 3; i++) push(1'b0, 4'b0010, 64, -1);
    t = 0;
    while (wr_start.size() < 2 && t < 2000) begin
      tick(1);
      t++;
    end
    chk("mid_reset_reach", 32'(t < 2000), 32'd1);
    tick(10);
    do_reset();
    chk_quiet("after_reset");
    k = cyc;
    push(1'b0, 4'b0010, 16, -1);
    wait_done(500);
    chk("after_reset_lat", rd_rise_cyc - k, 4);

    // Random traffic with random readiness noise.
    fork
      begin
        for (int f = 0; f < 60; f++) begin
          t = $urandom_range(0, 99);
          if (t < 10) ln = 0;
          else if (t < 13) ln = $urandom_range(1537, 1600);
          else ln = $urandom_range(1, 48);
          m = 4'($urandom);
          push(1'($urandom_range(0, 19) == 0), m, ln, -1);
          tick($urandom_range(0, 30));
        end
        wait_done(20000);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          tick(1);
          if ($urandom_range(0, 3) == 0) begin
            afull = 4'($urandom) & 4'($urandom);
            full  = 4'($urandom) & 4'($urandom) & 4'($urandom);
          end
        end
        afull = 4'd0;
        full = 4'd0;
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
